// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message buffer blocks.
//   BYTE_W  : width of one message byte
//   state_t : write-side loader states
package sha256_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/msg_loader_if.sv
// Byte-stream, memory-write and reader-handshake bundle of msg_loader.
//   in_valid/in_data/in_last/in_ready        : input byte stream
//   mem_write_enable/address/data            : message memory write port
//   msg_length/start/read_complete/overflow  : buffer status to/from reader
// slave  = msg_loader side, master = producer/memory/reader side.
interface msg_loader_if #(parameter int AW = 6);
   import sha256_pkg::*;

   logic              in_valid;
   logic [BYTE_W-1:0] in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_write_enable;
   logic [AW-1:0]     mem_write_address;
   logic [BYTE_W-1:0] mem_write_data;
   logic [AW-1:0]     msg_length;
   logic              start;
   logic              read_complete;
   logic              overflow;

   modport slave (
      input  in_valid, in_data, in_last, read_complete,
      output in_ready, mem_write_enable, mem_write_address, mem_write_data,
             msg_length, start, overflow
   );

   modport master (
      output in_valid, in_data, in_last, read_complete,
      input  in_ready, mem_write_enable, mem_write_address, mem_write_data,
             msg_length, start, overflow
   );

endinterface

// File: rtl/msg_loader_wr_addr_counter.sv
// Write address counter for the message buffer.
//   clock, reset : clock, async active-low reset
//   i_clr        : return to 0 (wins over i_inc)
//   i_inc        : advance by one
//   o_cnt        : current write address
//   o_tc         : address is at the last buffer slot
module wr_addr_counter #(
   parameter int MAX_COUNT = 55,
   parameter int AW        = $clog2(MAX_COUNT)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [AW-1:0] o_cnt,
   output logic          o_tc
);

   logic [AW-1:0] r_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)     r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + AW'(1);
   end

   assign o_cnt = r_cnt;
   assign o_tc  = (r_cnt == AW'(MAX_COUNT - 1));

endmodule

// File: rtl/msg_loader.sv
// Write-side front end of the SHA-256 message buffer. Stores streamed bytes
// at incrementing addresses, then holds start with msg_length until the
// reader reports read_complete.
//   clock, reset : clock, async active-low reset
//   bus          : msg_loader_if slave (stream, memory write, reader status)
//
//   state | meaning
//   LOAD  | accepting bytes, each one written to memory
//   DRAIN | message exceeded the buffer; accept and discard until in_last
//   HOLD  | buffer valid, start high, waiting for read_complete
module msg_loader
   import sha256_pkg::*;
#(
   parameter int MAX_MESSAGE_LENGTH = 55
) (
   input  logic         clock,
   input  logic         reset,
   msg_loader_if.slave  bus
);

   // MAX_MESSAGE_LENGTH must not be a power of two so the full length fits in AW.
   localparam int AW = $clog2(MAX_MESSAGE_LENGTH);

   state_t        r_state, w_next;
   logic [AW-1:0] w_cnt, r_len, w_len_nxt;
   logic          w_tc, w_hs, w_clr, w_inc, w_len_ld, w_ovf_set, w_ovf_clr;
   logic          r_ovf;

   wr_addr_counter #(.MAX_COUNT(MAX_MESSAGE_LENGTH), .AW(AW)) u_cnt (
      .clock (clock),
      .reset (reset),
      .i_clr (w_clr),
      .i_inc (w_inc),
      .o_cnt (w_cnt),
      .o_tc  (w_tc)
   );

   // Gated with reset so nothing is accepted while reset is asserted.
   assign bus.in_ready          = reset & (r_state != HOLD);
   assign w_hs                  = bus.in_valid & bus.in_ready;
   assign bus.mem_write_enable  = w_hs & (r_state == LOAD);
   assign bus.mem_write_address = w_cnt;
   assign bus.mem_write_data    = bus.in_data;
   assign bus.msg_length        = r_len;
   assign bus.start             = (r_state == HOLD);
   assign bus.overflow          = r_ovf;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= LOAD;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_clr     = 1'b0;
      w_inc     = 1'b0;
      w_len_ld  = 1'b0;
      w_len_nxt = r_len;
      w_ovf_set = 1'b0;
      w_ovf_clr = 1'b0;
      case (r_state)
         LOAD: begin
            if (w_hs) begin
               // overflow is only ever set at the end of a LOAD, so any LOAD
               // handshake that does not set it is the clearing point.
               w_ovf_clr = 1'b1;
               if (bus.in_last) begin
                  w_len_ld  = 1'b1;
                  w_len_nxt = w_cnt + AW'(1);
                  w_clr     = 1'b1;
                  w_next    = HOLD;
               end else if (w_tc) begin
                  w_len_ld  = 1'b1;
                  w_len_nxt = AW'(MAX_MESSAGE_LENGTH);
                  w_ovf_set = 1'b1;
                  w_clr     = 1'b1;
                  w_next    = DRAIN;
               end else begin
                  w_inc = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (w_hs && bus.in_last) w_next = HOLD;
         end
         HOLD: begin
            if (bus.read_complete) w_next = LOAD;
         end
         default: w_next = LOAD;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_len <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_len_ld)       r_len <= w_len_nxt;
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_msg_loader.sv
module tb_msg_loader;
   import sha256_pkg::*;

   localparam int MAXL = 55;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   msg_loader_if #(.AW(6)) bus ();

   msg_loader #(.MAX_MESSAGE_LENGTH(MAXL)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       l;
      logic       rc;
      logic       e_rdy;
      logic       e_we;
      logic [5:0] e_addr;
      logic       e_st;
      logic [5:0] e_len;
      logic       e_ovf;
   } vec_t;

   vec_t tbl[16];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [7:0] byte_of(input int i);
      return 8'((i * 7 + 3) & 255);
   endfunction

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic rc);
      @(posedge clk);
      #1;
      bus.in_valid      = v;
      bus.in_data       = d;
      bus.in_last       = l;
      bus.read_complete = rc;
      #4;
   endtask

   // Sends one n-byte message (optionally with random valid gaps), then
   // plays the reader until read_complete and checks the release cycle.
   task automatic send_msg(input int n, input bit gaps);
      int  sent;
      int  writes;
      int  exp_len;
      bit  v;
      exp_len = (n > MAXL) ? MAXL : n;
      sent    = 0;
      writes  = 0;
      while (sent < n) begin
         v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         drive(v, byte_of(sent), (sent == n - 1), 1'b0);
         chk("ready_in_load", bus.in_ready, 1);
         chk("start_in_load", bus.start, 0);
         chk("we_stream", bus.mem_write_enable, v && (sent < MAXL));
         if (v && sent < MAXL) begin
            chk("addr_stream", bus.mem_write_address, sent);
            chk("data_stream", bus.mem_write_data, byte_of(sent));
         end
         if (sent >= 1) chk("ovf_stream", bus.overflow, sent >= MAXL);
         if (bus.mem_write_enable) writes++;
         if (v) sent++;
      end
      chk("write_count", writes, exp_len);
      for (int i = 0; i < exp_len + 1; i++) begin
         drive(1'b1, 8'hEE, 1'b0, (i == exp_len - 1));
         chk("hold_start", bus.start, 1);
         chk("hold_ready", bus.in_ready, 0);
         chk("hold_we", bus.mem_write_enable, 0);
         chk("hold_len", bus.msg_length, exp_len);
         chk("hold_ovf", bus.overflow, n > MAXL);
         if (i == exp_len - 1) break;
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("release_start", bus.start, 0);
      chk("release_ready", bus.in_ready, 1);
      chk("release_len", bus.msg_length, exp_len);
   endtask

   initial begin
      bus.in_valid      = 1'b1;
      bus.in_data       = 8'h5A;
      bus.in_last       = 1'b0;
      bus.read_complete = 1'b0;

      tbl[0]  = '{1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0};
      tbl[1]  = '{1'b1, 8'h62, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 6'd0, 1'b0};
      tbl[2]  = '{1'b1, 8'h63, 1'b1, 1'b0, 1'b1, 1'b1, 6'd2, 1'b0, 6'd0, 1'b0};
      tbl[3]  = '{1'b1, 8'h64, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd3, 1'b0};
      tbl[4]  = '{1'b1, 8'h65, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd3, 1'b0};
      tbl[5]  = '{1'b1, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd3, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 6'd3, 1'b0};
      tbl[7]  = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 6'd3, 1'b0};
      tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd1, 1'b0};
      tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd1, 1'b0};
      tbl[10] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1, 6'd0, 1'b0, 6'd1, 1'b0};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 6'd1, 1'b0, 6'd1, 1'b0};
      tbl[12] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 6'd1, 1'b0};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b0};
      tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 6'd2, 1'b0};
      tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd2, 1'b0};

      // reset values, with in_valid high during reset
      repeat (2) @(posedge clk);
      #5;
      chk("rst_ready", bus.in_ready, 0);
      chk("rst_we", bus.mem_write_enable, 0);
      chk("rst_start", bus.start, 0);
      chk("rst_len", bus.msg_length, 0);
      chk("rst_ovf", bus.overflow, 0);
      chk("rst_addr", bus.mem_write_address, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.in_valid = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].rc);
         chk($sformatf("v%0d_ready", i), bus.in_ready, tbl[i].e_rdy);
         chk($sformatf("v%0d_we", i), bus.mem_write_enable, tbl[i].e_we);
         chk($sformatf("v%0d_addr", i), bus.mem_write_address, tbl[i].e_addr);
         chk($sformatf("v%0d_start", i), bus.start, tbl[i].e_st);
         chk($sformatf("v%0d_len", i), bus.msg_length, tbl[i].e_len);
         chk($sformatf("v%0d_ovf", i), bus.overflow, tbl[i].e_ovf);
         if (tbl[i].e_we) chk($sformatf("v%0d_data", i), bus.mem_write_data, tbl[i].d);
      end

      send_msg(55, 1'b0);   // exactly fills the buffer: no overflow
      send_msg(60, 1'b0);   // truncated, 5 bytes drained
      send_msg(20, 1'b1);   // random valid gaps
      send_msg(5, 1'b0);    // back-to-back set
      send_msg(1, 1'b0);
      send_msg(55, 1'b0);

      // reset in the middle of a 10-byte message, after 4 bytes
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, byte_of(i), 1'b0, 1'b0);
         chk("mid_addr", bus.mem_write_address, i);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      bus.in_valid = 1'b1;
      #1;
      chk("mid_rst_ready", bus.in_ready, 0);
      chk("mid_rst_we", bus.mem_write_enable, 0);
      chk("mid_rst_addr", bus.mem_write_address, 0);
      chk("mid_rst_len", bus.msg_length, 0);
      chk("mid_rst_start", bus.start, 0);
      chk("mid_rst_ovf", bus.overflow, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      bus.in_valid = 1'b0;
      send_msg(2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/msg_loader.md
# msg_loader

Write-side front end of the SHA-256 message buffer. It accepts message bytes on a valid/ready byte stream and writes them into the message memory at incrementing addresses. When the message ends, it publishes `msg_length` and holds `start` high so the read-side address counter can walk the buffer. It releases the buffer when that counter reports `read_complete`.

## Interface
Parameters:
- `MAX_MESSAGE_LENGTH`, 55 — buffer depth in bytes. Must not be a power of two, so that `msg_length` fits in AW bits.
- `AW`, `$clog2(MAX_MESSAGE_LENGTH)` — address and length width (6 by default). Local parameter; not overridable.

Ports:
- `clock`  in  1  — single clock; all state on its rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `in_valid`  in  1  — byte present on `in_data`.
- `in_data`  in  8  — message byte.
- `in_last`  in  1  — marks the final byte of a message.
- `in_ready`  out  1  — block can accept a byte.
- `mem_write_enable`  out  1  — memory write strobe.
- `mem_write_address`  out  AW  — byte address, starting at 0.
- `mem_write_data`  out  8  — byte to write.
- `msg_length`  out  AW  — length of the buffered message; stable while `start` = 1.
- `start`  out  1  — buffer full and valid; reader may run.
- `read_complete`  in  1  — from the read-side counter; high when its address equals `msg_length`-1.
- `overflow`  out  1  — sticky flag: the current message was truncated to `MAX_MESSAGE_LENGTH`.

## Operation
- A handshake is `in_valid & in_ready`, sampled at the rising edge.
- State machine has three states: LOAD, DRAIN, HOLD. The reset state is LOAD.
- **LOAD**
  - `in_ready` = 1.
  - Each handshake writes `in_data` to address `wr_cnt`, then increments `wr_cnt`.
  - Handshake with `in_last`: `msg_length` <= `wr_cnt`+1, `wr_cnt` <= 0, go to HOLD.
  - Handshake without `in_last` at `wr_cnt` = `MAX_MESSAGE_LENGTH`-1: `msg_length` <= `MAX_MESSAGE_LENGTH`, `overflow` <= 1, `wr_cnt` <= 0, go to DRAIN.
  - A message ending exactly at the final slot (`in_last` on byte `MAX_MESSAGE_LENGTH`) is not an overflow.
- **DRAIN**
  - `in_ready` = 1, no memory writes; bytes are discarded.
  - A handshake with `in_last` goes to HOLD.
- **HOLD**
  - `in_ready` = 0, `start` = 1.
  - `read_complete` sampled high goes to LOAD.
  - `read_complete` is ignored in every other state.
- `overflow` clears on the first handshake of the next message. It is otherwise stable.
- The message length is always at least 1, because every beat carries a byte. No zero-length messages exist.
- `wr_cnt` never exceeds `MAX_MESSAGE_LENGTH`-1. `mem_write_address` never wraps inside a message.

## Timing
- `mem_write_enable` = `in_valid & in_ready & (state == LOAD)`. This is combinational, so the memory captures the byte on the same edge as the handshake.
- `mem_write_address` = `wr_cnt` (registered). `mem_write_data` = `in_data` (pass-through).
- `in_ready` and `start` are decoded from the state register only. Neither has a combinational path from `in_valid`, `in_last` or `read_complete`.
- Latency from the last handshake (edge E) to `start` high is the cycle after E. `msg_length` is valid in the same cycle.
- `read_complete` high at edge E (in HOLD) makes `start` = 0 and `in_ready` = 1 in the cycle after E.
- `start` is low for at least one cycle between messages, because LOAD lasts at least one cycle. The reader sees an edge with `start` = 0 and returns its address to 0 before the next HOLD.
- Reset values: `start` 0, `msg_length` 0, `overflow` 0, `mem_write_address` 0, state LOAD.
  - While `reset` = 0: `in_ready` = 0 and `mem_write_enable` = 0.
- Reset asserted mid-LOAD, DRAIN or HOLD aborts the message immediately and asynchronously. The partial buffer contents are don't-care.

## Structure
- Shared package `sha256_pkg` holds the state enum (`LOAD`, `DRAIN`, `HOLD`) and the byte-width constant 8.
- `MAX_MESSAGE_LENGTH` stays a module parameter so it can match the read-side counter.
- Sub-module `wr_addr_counter` holds `wr_cnt` with clear and increment controls and a terminal-count output. Everything else is a single FSM module.

## Test plan
- **Basic load.** Bytes 0x61, 0x62, 0x63, `in_last` on 0x63, `in_valid` continuous → writes to addresses 0, 1, 2 in three consecutive cycles. `msg_length` = 3 and `start` = 1 the next cycle, with `in_ready` = 0. A reader model raises `read_complete` at address 2 → `start` = 0 and `in_ready` = 1 the following cycle.
- **Single byte.** One byte 0xAA with `in_last` → one write at address 0, `msg_length` = 1, `start` high. `read_complete` is honoured on the first HOLD cycle.
- **Boundary.**
  - 55 bytes with `in_last` on the 55th → addresses 0..54 written, `overflow` = 0, `msg_length` = 55.
  - 60 bytes with `in_last` on the 60th → 55 writes, `overflow` = 1, 5 bytes accepted with no writes, `msg_length` = 55. `start` rises the cycle after the 60th handshake.
- **Back-pressure and bubbles.**
  - Random `in_valid` gaps → address increments only on handshakes.
  - `in_valid` held high during HOLD → no handshake and no write.
  - Stray `read_complete` pulses in LOAD → ignored.
- **Reset mid-message.** Reset asserted after 4 bytes of a 10-byte message → outputs at reset values immediately. After release, a new 2-byte message writes addresses 0 and 1 with `msg_length` = 2.
- **Back-to-back.** Three messages of lengths 5, 1 and 55 with a reader model → `start` low for at least one cycle between messages. Each `msg_length` is correct and `overflow` stays 0.
